// File: rtl/tmds_period_sequencer_pkg.sv
// Shared encodings and small helpers for the TMDS period sequencer.
package tmds_period_sequencer_pkg;

    localparam int unsigned POS_W = 12;
    typedef logic [POS_W-1:0] pos_t;

    // Period FSM state codes double as the encoder mode output.
    localparam logic [1:0] MODE_CTRL     = 2'b00;
    localparam logic [1:0] MODE_PREAMBLE = 2'b01;
    localparam logic [1:0] MODE_GUARD    = 2'b10;
    localparam logic [1:0] MODE_VIDEO    = 2'b11;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

    function automatic logic in_window(input pos_t x, input pos_t lo, input pos_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/tmds_period_sequencer_if.sv
// Pixel handshake and encoder-control bundle between the sequencer and its neighbours.
interface tmds_period_sequencer_if;
    import tmds_period_sequencer_pkg::*;

    logic       pix_valid;
    logic       pix_req;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [1:0] mode;
    logic [3:0] ctl;
    logic       enc_clear;
    pos_t       h_pos;
    pos_t       v_pos;
    logic       frame_start;
    logic       underflow;

    modport master (
        input  pix_valid,
        output pix_req, de, hsync, vsync, mode, ctl, enc_clear,
        output h_pos, v_pos, frame_start, underflow
    );

    modport slave (
        output pix_valid,
        input  pix_req, de, hsync, vsync, mode, ctl, enc_clear,
        input  h_pos, v_pos, frame_start, underflow
    );

endinterface

// File: rtl/video_timing_counter.sv
// Raster h/v counters with wrap, hold-at-origin and one-position / next-line lookahead.
module video_timing_counter
    import tmds_period_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output pos_t h,
    output pos_t v,
    output logic active,
    output logic active_next,
    output logic next_line_active
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
    localparam pos_t H_ACT  = pos_t'(H_ACTIVE);
    localparam pos_t V_ACT  = pos_t'(V_ACTIVE);

    pos_t v_following;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (clear) begin
            h <= '0;
            v <= '0;
        end else if (advance) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= v_following;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Lookahead lets the registered outputs see one position ahead (pix_req, preamble).
    always_comb begin
        v_following      = (v == V_LAST) ? '0 : v + 1'b1;
        next_line_active = (v_following < V_ACT);
        active           = (h < H_ACT) && (v < V_ACT);
        if (h == H_LAST) begin
            active_next = next_line_active;
        end else begin
            active_next = ((h + 1'b1) < H_ACT) && (v < V_ACT);
        end
    end

endmodule

// File: rtl/tmds_period_sequencer.sv
// TMDS period scheduler: raster timing, encoder mode/CTL/disparity-clear control and pixel requests.
module tmds_period_sequencer
    import tmds_period_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter bit          HDMI_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    tmds_period_sequencer_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam pos_t PRE_START   = pos_t'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam pos_t GUARD_START = pos_t'(H_TOTAL - GUARD_LEN);
    localparam pos_t HS_START    = pos_t'(H_ACTIVE + H_FP);
    localparam pos_t HS_END      = pos_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam pos_t VS_START    = pos_t'(V_ACTIVE + V_FP);
    localparam pos_t VS_END      = pos_t'(V_ACTIVE + V_FP + V_SYNC);

    pos_t       h_cnt;
    pos_t       v_cnt;
    logic       active;
    logic       active_next;
    logic       next_line_active;
    logic       running;
    logic       advance;
    logic       clear;
    logic [1:0] mode_nxt;

    assign clear   = ~enable;
    assign advance = enable & running;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .advance          (advance),
        .h                (h_cnt),
        .v                (v_cnt),
        .active           (active),
        .active_next      (active_next),
        .next_line_active (next_line_active)
    );

    // Counter holds the position about to be output; mode_nxt is its period.
    always_comb begin
        mode_nxt = bus.mode;
        case (bus.mode)
            MODE_CTRL: begin
                if (active) begin
                    mode_nxt = MODE_VIDEO;
                end else if (HDMI_MODE && next_line_active && (h_cnt == PRE_START)) begin
                    mode_nxt = MODE_PREAMBLE;
                end
            end
            MODE_PREAMBLE: begin
                if (h_cnt == GUARD_START) mode_nxt = MODE_GUARD;
            end
            MODE_GUARD: begin
                if (h_cnt == '0) mode_nxt = active ? MODE_VIDEO : MODE_CTRL;
            end
            MODE_VIDEO: begin
                if (!active) mode_nxt = MODE_CTRL;
            end
            default: mode_nxt = MODE_CTRL;
        endcase
    end

    // The first enabled cycle only primes pix_req; counting starts on the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running         <= 1'b0;
            bus.mode        <= MODE_CTRL;
            bus.ctl         <= '0;
            bus.enc_clear   <= 1'b1;
            bus.de          <= 1'b0;
            bus.pix_req     <= 1'b0;
            bus.hsync       <= ~HSYNC_POL;
            bus.vsync       <= ~VSYNC_POL;
            bus.h_pos       <= '0;
            bus.v_pos       <= '0;
            bus.frame_start <= 1'b0;
            bus.underflow   <= 1'b0;
        end else begin
            bus.underflow <= bus.underflow | (bus.de & ~bus.pix_valid);
            if (!advance) begin
                running         <= enable;
                bus.mode        <= MODE_CTRL;
                bus.ctl         <= '0;
                bus.enc_clear   <= 1'b1;
                bus.de          <= 1'b0;
                bus.pix_req     <= enable & active;
                bus.hsync       <= ~HSYNC_POL;
                bus.vsync       <= ~VSYNC_POL;
                bus.h_pos       <= '0;
                bus.v_pos       <= '0;
                bus.frame_start <= 1'b0;
            end else begin
                bus.mode        <= mode_nxt;
                bus.ctl         <= (mode_nxt == MODE_PREAMBLE) ? CTL_VIDEO_PREAMBLE : '0;
                bus.enc_clear   <= (mode_nxt != MODE_VIDEO);
                bus.de          <= active;
                bus.pix_req     <= active_next;
                bus.hsync       <= in_window(h_cnt, HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
                bus.vsync       <= in_window(v_cnt, VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
                bus.h_pos       <= h_cnt;
                bus.v_pos       <= v_cnt;
                bus.frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_tmds_period_sequencer.sv
// Bench for tmds_period_sequencer: HDMI and DVI instances checked every cycle against a raster model.
module tb_tmds_period_sequencer;
    import tmds_period_sequencer_pkg::*;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 12;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pv = 1'b1;

    int n_assert = 0;
    int n_fail = 0;

    // Model: st 0 = idle, 1 = priming, 2 = outputting position (mh, mv).
    int st = 0;
    int mh = 0;
    int mv = 0;
    logic mu = 1'b0;

    tmds_period_sequencer_if bus_h ();
    tmds_period_sequencer_if bus_d ();

    assign bus_h.pix_valid = pv;
    assign bus_d.pix_valid = pv;

    tmds_period_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b1)
    ) dut_h (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus_h));

    tmds_period_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b0)
    ) dut_d (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus_d));

    always #5 clk = ~clk;

    function automatic logic act(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic [1:0] exp_mode(input bit hdmi, input int h, input int v);
        if (act(h, v)) return 2'b11;
        if (hdmi && (((v + 1) % VT) < VA)) begin
            if (h >= HT - 10 && h < HT - 2) return 2'b01;
            if (h >= HT - 2) return 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input bit hdmi,
                                 input logic pr, input logic de, input logic hs, input logic vs,
                                 input logic [1:0] md, input logic [3:0] ct, input logic ec,
                                 input logic [11:0] hp, input logic [11:0] vp,
                                 input logic fs, input logic uf);
        logic e_de, e_pr, e_hs, e_vs, e_fs;
        logic [1:0] e_md;
        int nh, nv;
        e_de = (st == 2) && act(mh, mv);
        e_md = (st == 2) ? exp_mode(hdmi, mh, mv) : 2'b00;
        if (st == 2) begin
            nh = mh + 1;
            nv = mv;
            if (nh == HT) begin
                nh = 0;
                nv = (mv + 1) % VT;
            end
            e_pr = act(nh, nv);
        end else begin
            e_pr = (st == 1);
        end
        e_hs = !((st == 2) && mh >= HA + HF && mh < HA + HF + HS);
        e_vs = !((st == 2) && mv >= VA + VF && mv < VA + VF + VS);
        e_fs = e_de && (mh == 0) && (mv == 0);
        chk({nm, " de"},          32'(de), 32'(e_de));
        chk({nm, " pix_req"},     32'(pr), 32'(e_pr));
        chk({nm, " hsync"},       32'(hs), 32'(e_hs));
        chk({nm, " vsync"},       32'(vs), 32'(e_vs));
        chk({nm, " mode"},        32'(md), 32'(e_md));
        chk({nm, " ctl"},         32'(ct), (e_md == 2'b01) ? 32'd1 : 32'd0);
        chk({nm, " enc_clear"},   32'(ec), 32'(e_md != 2'b11));
        chk({nm, " h_pos"},       32'(hp), (st == 2) ? 32'(mh) : 32'd0);
        chk({nm, " v_pos"},       32'(vp), (st == 2) ? 32'(mv) : 32'd0);
        chk({nm, " frame_start"}, 32'(fs), 32'(e_fs));
        chk({nm, " underflow"},   32'(uf), 32'(mu));
    endtask

    task automatic check_both();
        check_outputs("hdmi", 1'b1, bus_h.pix_req, bus_h.de, bus_h.hsync, bus_h.vsync, bus_h.mode,
                      bus_h.ctl, bus_h.enc_clear, bus_h.h_pos, bus_h.v_pos, bus_h.frame_start,
                      bus_h.underflow);
        check_outputs("dvi", 1'b0, bus_d.pix_req, bus_d.de, bus_d.hsync, bus_d.vsync, bus_d.mode,
                      bus_d.ctl, bus_d.enc_clear, bus_d.h_pos, bus_d.v_pos, bus_d.frame_start,
                      bus_d.underflow);
    endtask

    task automatic model_edge();
        logic de_now;
        de_now = (st == 2) && act(mh, mv);
        if (de_now && !pv) mu = 1'b1;
        if (!enable) begin
            st = 0;
            mh = 0;
            mv = 0;
        end else if (st == 0) begin
            st = 1;
        end else if (st == 1) begin
            st = 2;
            mh = 0;
            mv = 0;
        end else begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_both();
    endtask

    initial begin
        int k;
        int de_cnt;

        // Reset values while rst_n is held low.
        #12;
        check_both();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Start-up: first de cycle sits at the frame origin.
        enable = 1'b1;
        k = 0;
        while (bus_h.de !== 1'b1 && k < 5) begin
            step();
            k++;
        end
        chk("first de", 32'(bus_h.de), 32'd1);
        chk("first h_pos", 32'(bus_h.h_pos), 32'd0);
        chk("first v_pos", 32'(bus_h.v_pos), 32'd0);
        chk("first frame_start", 32'(bus_h.frame_start), 32'd1);
        de_cnt = 1;

        // Two full frames; one missing pixel at line 1, h 3 of the second frame.
        for (int c = 1; c < 2 * HT * VT; c++) begin
            step();
            if (c < HT * VT && mv == 0 && bus_h.de === 1'b1) de_cnt++;
            if (mv == 0 && mh == 15) chk("line0 preamble", 32'(bus_h.mode), 32'd1);
            if (mv == 3 && mh == 15) chk("line3 no preamble", 32'(bus_h.mode), 32'd0);
            if (mv == 6 && mh == 23) chk("line6 guard", 32'(bus_h.mode), 32'd2);
            pv = !(c >= HT * VT && mv == 1 && mh == 3);
        end
        chk("de per line", 32'(de_cnt), 32'(HA));
        chk("underflow held", 32'(bus_h.underflow), 32'd1);

        // Drop enable mid-line, then restart from the origin.
        pv = 1'b1;
        k = 0;
        while (!(mh == 4 && mv == 2) && k < 200) begin
            step();
            k++;
        end
        enable = 1'b0;
        step();
        chk("disable de", 32'(bus_h.de), 32'd0);
        chk("disable mode", 32'(bus_h.mode), 32'd0);
        step();
        enable = 1'b1;
        k = 0;
        while (bus_h.frame_start !== 1'b1 && k < 5) begin
            step();
            k++;
        end
        chk("restart frame_start", 32'(bus_h.frame_start), 32'd1);

        // Randomized pixel gaps and occasional enable drops.
        for (int c = 0; c < 300; c++) begin
            pv = ($urandom_range(0, 15) != 0);
            enable = ($urandom_range(0, 63) != 0);
            step();
        end

        // Asynchronous reset in the middle of a preamble.
        pv = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!(st == 2 && mh == 18 && ((mv + 1) % VT) < VA) && k < 400) begin
            step();
            k++;
        end
        chk("preamble before reset", 32'(bus_h.mode), 32'd1);
        #2;
        rst_n = 1'b0;
        st = 0;
        mh = 0;
        mv = 0;
        mu = 1'b0;
        #1;
        check_both();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
